cd_io_param: RTL

- Parametrised single-cycle datapath for the monocycle CPU, successor to the fixed 8-bit/10-bit datapath.
- Generalises data width, PC width and call-stack depth, and moves program memory outside the block (fetch ports).
- Adds memory-less I/O: registered input ports, registered output ports with write strobes, a carry flag and a stack-error flag.
- Sits between the control unit (opcode/flags out, control strobes in) and the external program ROM.

---
 rtl/cd_io_param_if.sv | 41 ++++
 rtl/cd_io_param.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cd_io_param_if.sv
// Bundle between the single-cycle datapath and its environment (control unit, program ROM, I/O pins).
// Purely combinational wiring; the datapath registers everything that needs registering.
// No backpressure: every strobe is taken in the cycle it is presented.
//
// Signals: instr_i/pc_o fetch pair; s_inc, s_wd, we3, wez, push, pop, we_out, op_alu control
// strobes; in_ports/out_ports/out_wr I/O; opcode, s_z, s_c, stk_err status to the control unit.
// Modports: master = environment side, slave = datapath side.
interface cd_io_param_if #(
  parameter int DW   = 8,
  parameter int PCW  = 10,
  parameter int NIN  = 4,
  parameter int NOUT = 4
);
  logic [DW+9:0]      instr_i;
  logic [PCW-1:0]     pc_o;
  logic               s_inc;
  logic [1:0]         s_wd;
  logic               we3;
  logic               wez;
  logic               push;
  logic               pop;
  logic               we_out;
  logic [2:0]         op_alu;
  logic [NIN*DW-1:0]  in_ports;
  logic [NOUT*DW-1:0] out_ports;
  logic [NOUT-1:0]    out_wr;
  logic [5:0]         opcode;
  logic               s_z;
  logic               s_c;
  logic               stk_err;

  modport master (
    output instr_i, s_inc, s_wd, we3, wez, push, pop, we_out, op_alu, in_ports,
    input  pc_o, out_ports, out_wr, opcode, s_z, s_c, stk_err
  );

  modport slave (
    input  instr_i, s_inc, s_wd, we3, wez, push, pop, we_out, op_alu, in_ports,
    output pc_o, out_ports, out_wr, opcode, s_z, s_c, stk_err
  );
endinterface

// File: rtl/cd_io_param.sv
// Parametrised single-cycle CPU datapath: regfile, ALU, flags, return stack, registered I/O ports.
// One instruction per clock; input ports have one cycle of sampling latency, outputs update at the edge.
// No backpressure: control strobes are consumed every cycle, stack misuse raises sticky stk_err.
//
// Ports: clk, reset (synchronous, active-high), bus (cd_io_param_if.slave: fetch, control, I/O, status).
// Optional feature: define CD_IO_PARAM_CARRY_EN to implement the carry/borrow flag; when undefined
// s_c is tied to 0 and wez updates Z only.
module cd_io_param #(
  parameter int DW     = 8,
  parameter int PCW    = 10,
  parameter int SDEPTH = 8,
  parameter int NIN    = 4,
  parameter int NOUT   = 4
) (
  input  logic         clk,
  input  logic         reset,
  cd_io_param_if.slave bus
);
  localparam int IW  = DW + 10;
  localparam int SAW = $clog2(SDEPTH);      // stack entry index width
  localparam int SPW = $clog2(SDEPTH + 1);  // pointer counts 0..SDEPTH valid entries

  // Instruction fields
  logic [IW-1:0]  instr;
  logic [3:0]     rd, rs1, rs2;
  logic [DW-1:0]  imm;
  logic [PCW-1:0] jaddr;
  logic [3:0]     in_idx, out_idx;

  assign instr   = bus.instr_i;
  assign rd      = instr[3:0];
  assign rs2     = instr[DW-1:DW-4];
  assign rs1     = instr[DW+3:DW];
  assign imm     = instr[DW+3:4];
  assign jaddr   = instr[PCW-1:0];
  // Port counts are powers of two, so masking keeps the index in range.
  assign in_idx  = rs1 & 4'(NIN - 1);
  assign out_idx = rd & 4'(NOUT - 1);
  assign bus.opcode = instr[IW-1:IW-6];

  // State
  logic [PCW-1:0]     pc_q;
  logic [DW-1:0]      rf [16];
  logic               z_q;
  logic [PCW-1:0]     stk [SDEPTH];
  logic [SPW-1:0]     sp_q;
  logic [NOUT*DW-1:0] out_q;
  logic [NOUT-1:0]    wr_q;
  logic               err_q;
  logic [NIN*DW-1:0]  in_q;

  // Register reads, R0 hard-wired to zero
  logic [DW-1:0] a, b;
  assign a = (rs1 == 4'd0) ? '0 : rf[rs1];
  assign b = (rs2 == 4'd0) ? '0 : rf[rs2];

  // ALU
  logic [DW-1:0] alu_res;
  always_comb begin
    alu_res = a;
    unique case (bus.op_alu)
      3'b000: alu_res = a;
      3'b001: alu_res = ~a;
      3'b010: alu_res = a + b;
      3'b011: alu_res = a - b;
      3'b100: alu_res = a & b;
      3'b101: alu_res = a | b;
      3'b110: alu_res = '0 - a;
      3'b111: alu_res = '0 - b;
    endcase
  end

  // Register write-data select; code 11 falls back to the ALU
  logic [DW-1:0] wd;
  always_comb begin
    case (bus.s_wd)
      2'b01:   wd = imm;
      2'b10:   wd = in_q[int'(in_idx)*DW +: DW];
      default: wd = alu_res;
    endcase
  end

  // Return stack and next PC
  logic           empty, full, err_set;
  logic [PCW-1:0] pc_inc, top, pc_nxt;

  assign empty  = (sp_q == '0);
  assign full   = (sp_q == SPW'(SDEPTH));
  assign pc_inc = pc_q + PCW'(1);
  assign top    = stk[SAW'(sp_q - SPW'(1))];
  // Pop wins over push; any push+pop, push-when-full or pop-when-empty is an error.
  assign err_set = (bus.pop & (bus.push | empty)) | (bus.push & full);

  always_comb begin
    if (bus.pop)        pc_nxt = empty ? '0 : top;
    else if (bus.s_inc) pc_nxt = pc_inc;
    else                pc_nxt = jaddr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      z_q   <= 1'b0;
      sp_q  <= '0;
      out_q <= '0;
      wr_q  <= '0;
      err_q <= 1'b0;
      in_q  <= '0;
    end else begin
      pc_q <= pc_nxt;
      in_q <= bus.in_ports;
      if (bus.we3 && rd != 4'd0) rf[rd] <= wd;
      if (bus.wez) z_q <= (alu_res == '0);
      if (bus.pop) begin
        if (!empty) sp_q <= sp_q - SPW'(1);
      end else if (bus.push && !full) begin
        sp_q <= sp_q + SPW'(1);
      end
      if (err_set) err_q <= 1'b1;
      wr_q <= '0;
      if (bus.we_out) begin
        out_q[int'(out_idx)*DW +: DW] <= a;
        wr_q <= NOUT'(1) << out_idx;
      end
    end
  end

  // Stack storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge clk) begin
    if (!reset && !bus.pop && bus.push && !full) stk[SAW'(sp_q)] <= pc_inc;
  end

`ifdef CD_IO_PARAM_CARRY_EN
  // Add carries out exactly when the wrapped sum is below an operand; subtract borrows when A<B.
  logic alu_cy, c_q;
  assign alu_cy = (bus.op_alu == 3'b010) ? (alu_res < a) :
                  (bus.op_alu == 3'b011) ? (a < b) : 1'b0;
  always_ff @(posedge clk) begin
    if (reset)        c_q <= 1'b0;
    else if (bus.wez) c_q <= alu_cy;
  end
  assign bus.s_c = c_q;
`else
  assign bus.s_c = 1'b0;
`endif

  assign bus.pc_o      = pc_q;
  assign bus.s_z       = z_q;
  assign bus.out_ports = out_q;
  assign bus.out_wr    = wr_q;
  assign bus.stk_err   = err_q;
endmodule
